// File: rtl/wb_uart_debug_bridge.sv
// -----------------------------------------------------------------------------
// wb_uart_debug_bridge
//
// Wishbone classic master controlled by a host byte stream (typically a UART
// receiver). The host can peek and poke the SoC address map without the CPU.
//
// Command protocol (all multi-byte fields MSB first):
//   0x57 'W' + 4 address bytes + 4 data bytes -> single 32-bit write
//   0x52 'R' + 4 address bytes                -> single 32-bit read
// Responses:
//   0x06 success (a read then returns 4 data bytes, MSB first)
//   0x15 bus error (err or rty terminated the cycle, or bus timeout)
//   0x3F unknown command byte
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   rx_data_i, rx_valid_i  host byte stream in (no backpressure)
//   tx_data_o, tx_valid_o, tx_ready_i  response byte stream out
//   wbm_*                  Wishbone classic master port
//   busy_o                 high whenever the bridge is not idle
//
// Optional feature: define WB_BRIDGE_TIMEOUT_EN to abort a bus cycle that
// sees no termination within TIMEOUT cycles (reported as 0x15). Without the
// macro the bridge waits for termination indefinitely.
// -----------------------------------------------------------------------------
module wb_uart_debug_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h06;
    localparam logic [7:0] RSP_ERR   = 8'h15;
    localparam logic [7:0] RSP_UNK   = 8'h3F;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;        // byte index within a field
    logic        write_q, write_d;    // current command is a write
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;    // read data, shifted out MSB first
    logic        rd_ok_q, rd_ok_d;    // status byte is followed by read data
    logic        cyc_q, cyc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;

    logic tx_fire;
    logic bus_abort;

    assign tx_fire = tx_valid_q & tx_ready_i;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Held at zero outside BUS, so every bus cycle starts counting from 0.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_BUS) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Fires on the edge closing the TIMEOUT-th cycle with CYC high.
    assign bus_abort = (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    assign bus_abort = 1'b0;
`endif

    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        rd_ok_d    = rd_ok_q;
        cyc_d      = cyc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                        write_d = (rx_data_i == CMD_WRITE);
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        tx_data_d  = RSP_UNK;
                        tx_valid_d = 1'b1;
                        rd_ok_d    = 1'b0;
                        state_d    = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (rx_valid_i) begin
                    adr_d = {adr_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;     // wraps to 0 for the data field
                    if (cnt_q == 2'd3) begin
                        if (write_q) begin
                            state_d = S_DATA;
                        end else begin
                            cyc_d   = 1'b1;
                            state_d = S_BUS;
                        end
                    end
                end
            end

            S_DATA: begin
                if (rx_valid_i) begin
                    dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cyc_d   = 1'b1;
                        state_d = S_BUS;
                    end
                end
            end

            S_BUS: begin
                // ack is checked first so it wins over a simultaneous err/rty.
                if (wbm_ack_i) begin
                    cyc_d      = 1'b0;
                    tx_data_d  = RSP_OK;
                    tx_valid_d = 1'b1;
                    rd_ok_d    = ~write_q;
                    if (!write_q) begin
                        rdata_d = wbm_dat_i;
                    end
                    state_d = S_RESP;
                end else if (wbm_err_i || wbm_rty_i || bus_abort) begin
                    cyc_d      = 1'b0;
                    tx_data_d  = RSP_ERR;
                    tx_valid_d = 1'b1;
                    rd_ok_d    = 1'b0;
                    state_d    = S_RESP;
                end
            end

            S_RESP: begin
                if (tx_fire) begin
                    if (rd_ok_q) begin
                        // Present the first data byte immediately: no gap.
                        tx_data_d = rdata_q[31:24];
                        rdata_d   = {rdata_q[23:0], 8'h00};
                        cnt_d     = 2'd0;
                        state_d   = S_RDATA;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_RDATA: begin
                if (tx_fire) begin
                    if (cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = rdata_q[31:24];
                        rdata_d   = {rdata_q[23:0], 8'h00};
                        cnt_d     = cnt_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            write_q    <= 1'b0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            rdata_q    <= 32'h0;
            rd_ok_q    <= 1'b0;
            cyc_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            rd_ok_q    <= rd_ok_d;
            cyc_q      <= cyc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_sel_o  = {4{cyc_q}};
    assign wbm_we_o   = cyc_q & write_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_uart_debug_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for wb_uart_debug_bridge.
// Inputs are driven 2 time units after the rising edge; outputs are sampled
// on the falling edge. A small Wishbone slave model provides configurable
// wait states and termination type; a monitor logs transferred tx bytes,
// counts STB cycles and records the bus signals at termination.
// -----------------------------------------------------------------------------
module tb_wb_uart_debug_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err, wbm_rty;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_uart_debug_bridge #(.TIMEOUT(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .wbm_adr_o  (wbm_adr),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel),
        .wbm_we_o   (wbm_we),
        .wbm_cyc_o  (wbm_cyc),
        .wbm_stb_o  (wbm_stb),
        .wbm_cti_o  (wbm_cti),
        .wbm_bte_o  (wbm_bte),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack),
        .wbm_err_i  (wbm_err),
        .wbm_rty_i  (wbm_rty),
        .busy_o     (busy)
    );

    // tx_ready: fixed level, or toggling every cycle when tog_en is set.
    logic rdy_fix;
    logic tog_en;
    logic tog_q = 1'b0;
    always @(posedge clk) tog_q <= ~tog_q;
    assign tx_ready = tog_en ? tog_q : rdy_fix;

    // Slave model: mode 0 ack, 1 err, 2 rty, 3 never terminates.
    logic [1:0]  sl_mode;
    int          sl_waits;
    logic [31:0] sl_rdata;
    int          sl_cnt = 0;
    logic        sl_hit;
    assign sl_hit    = wbm_cyc && wbm_stb && (sl_cnt >= sl_waits) && (sl_mode != 2'd3);
    assign wbm_ack   = sl_hit && (sl_mode == 2'd0);
    assign wbm_err   = sl_hit && (sl_mode == 2'd1);
    assign wbm_rty   = sl_hit && (sl_mode == 2'd2);
    assign wbm_dat_i = sl_hit ? sl_rdata : 32'hA5A5_A5A5;
    always @(posedge clk) begin
        if (wbm_cyc && wbm_stb && !sl_hit) sl_cnt <= sl_cnt + 1;
        else sl_cnt <= 0;
    end

    // Monitor.
    logic [7:0]  tx_log[$];
    int          stb_cycles = 0;
    int          stab_viol  = 0;
    int          hold_cnt   = 0;
    logic        hold_q     = 1'b0;
    logic [7:0]  hold_data  = 8'h00;
    logic [31:0] t_adr = 32'h0, t_dat = 32'h0;
    logic        t_we  = 1'b0;
    logic [3:0]  t_sel = 4'h0;
    always @(negedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q && (!tx_valid || tx_data !== hold_data)) stab_viol <= stab_viol + 1;
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (tx_valid && !tx_ready) hold_cnt <= hold_cnt + 1;
            hold_q    <= tx_valid && !tx_ready;
            hold_data <= tx_data;
            if (wbm_cyc && wbm_stb) begin
                stb_cycles <= stb_cycles + 1;
                if (wbm_ack || wbm_err || wbm_rty) begin
                    t_adr <= wbm_adr;
                    t_dat <= wbm_dat_o;
                    t_we  <= wbm_we;
                    t_sel <= wbm_sel;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [71:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = bytes[8*(n-1-i) +: 8];
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || tx_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || tx_valid) begin
            errors++;
            $display("FAIL %s_idle: still busy after %0d cycles", name, max);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rdy_fix = 1'b1; tog_en = 1'b0;
        sl_mode = 2'd0; sl_waits = 0; sl_rdata = 32'h0;
        repeat (3) step();
        @(negedge clk);
        checks++; if (wbm_adr !== 32'h0 || wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_adr_dat: adr=%h dat=%h expected 0", wbm_adr, wbm_dat_o); end
        checks++; if (wbm_sel !== 4'h0 || wbm_we !== 1'b0) begin errors++; $display("FAIL reset_sel_we: sel=%h we=%b expected 0", wbm_sel, wbm_we); end
        checks++; if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: cyc=%b stb=%b expected 0", wbm_cyc, wbm_stb); end
        checks++; if (wbm_cti !== 3'b000 || wbm_bte !== 2'b00) begin errors++; $display("FAIL reset_cti_bte: cti=%b bte=%b expected 0", wbm_cti, wbm_bte); end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: valid=%b data=%h expected 0/00", tx_valid, tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        sl_mode = 2'd0; sl_waits = 0;
        send(72'h57_00_00_10_04_DE_AD_BE_EF, 9);
        @(negedge clk);
        checks++; if (wbm_cyc !== 1'b1 || wbm_stb !== 1'b1) begin errors++; $display("FAIL write_cyc_rise: cyc=%b stb=%b expected 1", wbm_cyc, wbm_stb); end
        checks++; if (wbm_adr !== 32'h0000_1004) begin errors++; $display("FAIL write_adr: got %h expected 00001004", wbm_adr); end
        checks++; if (wbm_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_dat: got %h expected deadbeef", wbm_dat_o); end
        checks++; if (wbm_we !== 1'b1 || wbm_sel !== 4'hF) begin errors++; $display("FAIL write_we_sel: we=%b sel=%h expected 1/f", wbm_we, wbm_sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
        step();
        @(negedge clk);
        checks++; if (wbm_cyc !== 1'b0 || wbm_sel !== 4'h0) begin errors++; $display("FAIL write_cyc_fall: cyc=%b sel=%h expected 0/0", wbm_cyc, wbm_sel); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin errors++; $display("FAIL write_status: valid=%b data=%h expected 1/06", tx_valid, tx_data); end
        wait_idle(20, "write");
        checks++; if (stb_cycles - base_stb != 1) begin errors++; $display("FAIL write_stb_len: got %0d expected 1", stb_cycles - base_stb); end
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h06) begin errors++; $display("FAIL write_tx: got %0d bytes, first %h, expected 1 byte 06", tx_log.size() - base_tx, tx_log[base_tx]); end
    endtask

    task automatic test_read_wait();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        int base_sv  = stab_viol;
        int base_hd  = hold_cnt;
        logic [39:0] exp = 40'h06_12_34_56_78;
        sl_mode = 2'd0; sl_waits = 3; sl_rdata = 32'h1234_5678;
        tog_en = 1'b1;
        send(72'h52_00_00_00_08, 5);
        wait_idle(60, "read");
        tog_en = 1'b0;
        checks++; if (stb_cycles - base_stb != 4) begin errors++; $display("FAIL read_stb_len: got %0d expected 4", stb_cycles - base_stb); end
        checks++; if (t_adr !== 32'h8 || t_we !== 1'b0 || t_sel !== 4'hF) begin errors++; $display("FAIL read_bus: adr=%h we=%b sel=%h expected 00000008/0/f", t_adr, t_we, t_sel); end
        checks++;
        if (tx_log.size() - base_tx != 5) begin
            errors++; $display("FAIL read_tx_len: got %0d expected 5", tx_log.size() - base_tx);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (tx_log[base_tx+i] !== exp[8*(4-i) +: 8]) begin errors++; $display("FAIL read_tx_byte%0d: got %h expected %h", i, tx_log[base_tx+i], exp[8*(4-i) +: 8]); end
            end
        end
        checks++; if (hold_cnt == base_hd) begin errors++; $display("FAIL read_hold: got 0 stall cycles expected >0"); end
        checks++; if (stab_viol != base_sv) begin errors++; $display("FAIL read_stable: got %0d violations expected 0", stab_viol - base_sv); end
    endtask

    task automatic test_err_rty();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        sl_mode = 2'd1; sl_waits = 0;
        send(72'h57_00_00_00_20_CA_FE_F0_0D, 9);
        wait_idle(20, "err");
        checks++; if (stb_cycles - base_stb != 1 || t_we !== 1'b1) begin errors++; $display("FAIL err_bus: stb=%0d we=%b expected 1/1", stb_cycles - base_stb, t_we); end
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h15) begin errors++; $display("FAIL err_tx: got %0d bytes, first %h, expected 1 byte 15", tx_log.size() - base_tx, tx_log[base_tx]); end
        base_tx = tx_log.size();
        sl_mode = 2'd2; sl_rdata = 32'h7777_7777;
        send(72'h52_00_00_00_24, 5);
        wait_idle(20, "rty");
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h15) begin errors++; $display("FAIL rty_tx: got %0d bytes, first %h, expected 1 byte 15", tx_log.size() - base_tx, tx_log[base_tx]); end
        sl_mode = 2'd0;
    endtask

    task automatic test_unknown();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        send(72'h41, 1);
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin errors++; $display("FAIL unk_status: valid=%b data=%h expected 1/3f", tx_valid, tx_data); end
        checks++; if (wbm_cyc !== 1'b0) begin errors++; $display("FAIL unk_cyc: got %b expected 0", wbm_cyc); end
        wait_idle(20, "unk");
        checks++; if (stb_cycles != base_stb) begin errors++; $display("FAIL unk_no_bus: got %0d stb cycles expected 0", stb_cycles - base_stb); end
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h3F) begin errors++; $display("FAIL unk_tx: got %0d bytes, first %h, expected 1 byte 3f", tx_log.size() - base_tx, tx_log[base_tx]); end
    endtask

    task automatic test_dropped();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        logic [39:0] exp = 40'h06_CA_FE_BA_BE;
        sl_mode = 2'd0; sl_waits = 5; sl_rdata = 32'hCAFE_BABE;
        send(72'h52_00_00_00_40, 5);
        send(72'h57_52_41, 3);            // arrives while the bus cycle runs
        wait_idle(40, "drop_read");
        checks++; if (stb_cycles - base_stb != 6) begin errors++; $display("FAIL drop_stb_len: got %0d expected 6", stb_cycles - base_stb); end
        checks++;
        if (tx_log.size() - base_tx != 5) begin
            errors++; $display("FAIL drop_tx_len: got %0d expected 5", tx_log.size() - base_tx);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (tx_log[base_tx+i] !== exp[8*(4-i) +: 8]) begin errors++; $display("FAIL drop_tx_byte%0d: got %h expected %h", i, tx_log[base_tx+i], exp[8*(4-i) +: 8]); end
            end
        end
        base_tx = tx_log.size();
        sl_waits = 0;
        send(72'h57_AA_BB_CC_DC_11_22_33_44, 9);
        wait_idle(20, "drop_next");
        checks++; if (t_adr !== 32'hAABB_CCDC || t_dat !== 32'h1122_3344 || t_we !== 1'b1) begin errors++; $display("FAIL drop_next_bus: adr=%h dat=%h we=%b expected aabbccdc/11223344/1", t_adr, t_dat, t_we); end
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h06) begin errors++; $display("FAIL drop_next_tx: got %0d bytes, first %h, expected 1 byte 06", tx_log.size() - base_tx, tx_log[base_tx]); end
    endtask

    task automatic test_reset_mid();
        int base_tx;
        send(72'h52_AB_CD, 3);
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || wbm_adr !== 32'h0 || tx_valid !== 1'b0 || wbm_cyc !== 1'b0) begin errors++; $display("FAIL rst_addr: busy=%b adr=%h txv=%b cyc=%b expected all 0", busy, wbm_adr, tx_valid, wbm_cyc); end
        step();
        rst = 1'b0;
        base_tx = tx_log.size();
        sl_mode = 2'd0; sl_waits = 0; sl_rdata = 32'h0BAD_F00D;
        send(72'h52_00_00_00_0C, 5);
        wait_idle(20, "rst_reparse");
        checks++; if (t_adr !== 32'h0000_000C) begin errors++; $display("FAIL rst_reparse_adr: got %h expected 0000000c", t_adr); end
        checks++; if (tx_log.size() - base_tx != 5 || tx_log[base_tx+1] !== 8'h0B) begin errors++; $display("FAIL rst_reparse_tx: got %0d bytes expected 5 starting 06 0b", tx_log.size() - base_tx); end

        base_tx = tx_log.size();
        sl_mode = 2'd3;
        send(72'h52_00_00_00_10, 5);
        step();
        @(negedge clk);
        checks++; if (wbm_cyc !== 1'b1) begin errors++; $display("FAIL rst_bus_pre: cyc=%b expected 1", wbm_cyc); end
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++; if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0 || wbm_sel !== 4'h0) begin errors++; $display("FAIL rst_bus_cyc: cyc=%b stb=%b sel=%h expected 0", wbm_cyc, wbm_stb, wbm_sel); end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rst_bus_state: busy=%b txv=%b expected 0/0", busy, tx_valid); end
        step();
        rst = 1'b0;
        sl_mode = 2'd0;
        repeat (5) step();
        checks++; if (tx_log.size() != base_tx) begin errors++; $display("FAIL rst_bus_tx: got %0d bytes expected 0", tx_log.size() - base_tx); end
    endtask

    task automatic test_timeout();
        int base_stb = stb_cycles;
        int base_tx  = tx_log.size();
        sl_mode = 2'd3;
        send(72'h52_00_00_00_14, 5);
`ifdef WB_BRIDGE_TIMEOUT_EN
        wait_idle(100, "timeout");
        checks++; if (stb_cycles - base_stb != 16) begin errors++; $display("FAIL timeout_len: got %0d expected 16", stb_cycles - base_stb); end
        checks++; if (tx_log.size() - base_tx != 1 || tx_log[base_tx] !== 8'h15) begin errors++; $display("FAIL timeout_tx: got %0d bytes, first %h, expected 1 byte 15", tx_log.size() - base_tx, tx_log[base_tx]); end
`else
        repeat (1000) step();
        @(negedge clk);
        checks++; if (wbm_cyc !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL hang_cyc: cyc=%b busy=%b expected 1/1", wbm_cyc, busy); end
        checks++; if (stb_cycles - base_stb < 1000 || tx_log.size() != base_tx) begin errors++; $display("FAIL hang_tx: stb=%0d bytes=%0d expected >=1000/0", stb_cycles - base_stb, tx_log.size() - base_tx); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        sl_mode = 2'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_err_rty();
        test_unknown();
        test_dropped();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
